jtcop_gfx_rom_resp: RTL

//  Responder for the three BAC06 tile ROM request ports (bN_rom_cs/addr -> data/ok).

---
 rtl/jtcop_gfx_rom_resp_pkg.sv | 24 ++
 rtl/jtcop_gfx_rom_resp_slot.sv | 41 ++++
 rtl/jtcop_gfx_rom_resp.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/jtcop_gfx_rom_resp_pkg.sv
// Shared definitions for the BAC06 tile ROM responder: client count, default
// address map and fetch FSM states.
package jtcop_gfx_rom_resp_pkg;

   localparam int          NCLIENT   = 3;
   localparam int          AW_DEF    = 17;
   localparam logic [21:0] BASE0_DEF = 22'h000000;
   localparam logic [21:0] BASE1_DEF = 22'h040000;
   localparam logic [21:0] BASE2_DEF = 22'h080000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_LO,
      ST_WAIT_LO,
      ST_REQ_HI,
      ST_WAIT_HI
   } fetch_st_e;

   // Round-robin successor over clients 0,1,2.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/jtcop_gfx_rom_resp_slot.sv
// One-entry 32-bit cache for a single ROM client: tag, data, valid bit,
// combinational hit/ok, fill port and invalidate.
module jtcop_gfx_rom_resp_slot #(
   parameter int AW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          inval,
   input  logic          we,
   input  logic [AW-1:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic [31:0]   data,
   output logic          ok,
   output logic          miss
);

   logic          valid;
   logic [AW-1:0] tag;
   logic          hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (we) begin
         valid <= 1'b1;
         tag   <= fill_tag;
         data  <= fill_data;
      end else if (inval) begin
         valid <= 1'b0;
      end
   end

   assign hit  = valid && (addr == tag);
   assign ok   = cs && hit;
   assign miss = cs && !hit;

endmodule

// File: rtl/jtcop_gfx_rom_resp.sv
// Tile ROM responder: three cached clients sharing one 16-bit SDRAM read port,
// round-robin arbitration, each miss fetched as two consecutive 16-bit words.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no fetch; grant the next missing client from the rr pointer
// ST_REQ_LO  | sdr_req held for the even (low) word until sdr_ack
// ST_WAIT_LO | waiting for sdr_rdy with the low word
// ST_REQ_HI  | sdr_req held for the odd (high) word until sdr_ack
// ST_WAIT_HI | waiting for sdr_rdy with the high word, then fill the slot
module jtcop_gfx_rom_resp
   import jtcop_gfx_rom_resp_pkg::*;
#(
   parameter int          AW    = AW_DEF,
   parameter logic [21:0] BASE0 = BASE0_DEF,
   parameter logic [21:0] BASE1 = BASE1_DEF,
   parameter logic [21:0] BASE2 = BASE2_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          b0_cs,
   input  logic [AW-1:0] b0_addr,
   output logic [31:0]   b0_data,
   output logic          b0_ok,
   input  logic          b1_cs,
   input  logic [AW-1:0] b1_addr,
   output logic [31:0]   b1_data,
   output logic          b1_ok,
   input  logic          b2_cs,
   input  logic [AW-1:0] b2_addr,
   output logic [31:0]   b2_data,
   output logic          b2_ok,
   output logic          sdr_req,
   output logic [21:0]   sdr_addr,
   input  logic          sdr_ack,
   input  logic [15:0]   sdr_dout,
   input  logic          sdr_rdy
);

   logic [NCLIENT-1:0] cs, miss, ok, inval, fill_we;
   logic [AW-1:0]      addr [NCLIENT];
   logic [31:0]        data [NCLIENT];

   fetch_st_e     st;
   logic [1:0]    rr, rr1, rr2, gnt, fetch_id;
   logic          gnt_valid;
   logic [AW-1:0] gnt_addr, fetch_tag;
   logic [21:0]   gnt_base;
   logic [15:0]   lo;

   assign cs      = {b2_cs, b1_cs, b0_cs};
   assign addr[0] = b0_addr;
   assign addr[1] = b1_addr;
   assign addr[2] = b2_addr;
   assign b0_data = data[0];
   assign b1_data = data[1];
   assign b2_data = data[2];
   assign b0_ok   = ok[0];
   assign b1_ok   = ok[1];
   assign b2_ok   = ok[2];

   assign rr1 = rr_next(rr);
   assign rr2 = rr_next(rr1);

   always_comb begin
      gnt_valid = 1'b1;
      gnt       = rr;
      if (miss[rr])       gnt = rr;
      else if (miss[rr1]) gnt = rr1;
      else if (miss[rr2]) gnt = rr2;
      else                gnt_valid = 1'b0;
   end

   assign gnt_addr = addr[gnt];

   always_comb begin
      case (gnt)
         2'd0:    gnt_base = BASE0;
         2'd1:    gnt_base = BASE1;
         default: gnt_base = BASE2;
      endcase
   end

   // The granted slot drops valid at grant so a half-filled entry never hits.
   for (genvar n = 0; n < NCLIENT; n++) begin : g_slot
      assign inval[n]   = (st == ST_IDLE) && gnt_valid && (gnt == 2'(n));
      assign fill_we[n] = (st == ST_WAIT_HI) && sdr_rdy && (fetch_id == 2'(n));

      jtcop_gfx_rom_resp_slot #(.AW(AW)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .cs        (cs[n]),
         .addr      (addr[n]),
         .inval     (inval[n]),
         .we        (fill_we[n]),
         .fill_tag  (fetch_tag),
         .fill_data ({sdr_dout, lo}),
         .data      (data[n]),
         .ok        (ok[n]),
         .miss      (miss[n])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         rr        <= 2'd0;
         fetch_id  <= 2'd0;
         fetch_tag <= '0;
         lo        <= '0;
         sdr_req   <= 1'b0;
         sdr_addr  <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (gnt_valid) begin
                  fetch_id  <= gnt;
                  fetch_tag <= gnt_addr;
                  sdr_addr  <= gnt_base + (22'(gnt_addr) << 1);
                  sdr_req   <= 1'b1;
                  rr        <= rr_next(gnt);
                  st        <= ST_REQ_LO;
               end
            end
            ST_REQ_LO: begin
               if (sdr_ack) begin
                  sdr_req <= 1'b0;
                  st      <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               if (sdr_rdy) begin
                  lo       <= sdr_dout;
                  sdr_addr <= sdr_addr + 22'd1;
                  sdr_req  <= 1'b1;
                  st       <= ST_REQ_HI;
               end
            end
            ST_REQ_HI: begin
               if (sdr_ack) begin
                  sdr_req <= 1'b0;
                  st      <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (sdr_rdy) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
